seq_program_controller: RTL and testbench

//  Multi-instruction sequencer driving the ALU datapath from a synchronous instruction ROM.

---
 rtl/seq_program_controller_pkg.sv | 17 +
 rtl/seq_program_controller_if.sv | 22 ++
 rtl/seq_program_controller_watchdog.sv | 19 +
 rtl/seq_program_controller.sv | 131 +++++++++++++
 tb/tb_seq_program_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_program_controller_pkg.sv
// seq_ctrl_pkg: shared FSM states, opcode classes and opcode decode for the program sequencer
package seq_ctrl_pkg;
  localparam int DEF_OP_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR = 5;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ERROR} state_e;
  typedef enum logic [2:0] {OP_ALU, OP_NOP, OP_JMP, OP_HALT, OP_BAD} op_class_e;
  // The three control opcodes sit at the top of the opcode space, so they move with op_w.
  function automatic op_class_e op_class(input logic [31:0] op, input int op_w, input int n_alu);
    logic [31:0] ones;
    ones = (32'd1 << op_w) - 32'd1;
    return op < 32'(n_alu) ? OP_ALU :
           op == ones - 32'd2 ? OP_NOP :
           op == ones - 32'd1 ? OP_JMP :
           op == ones ? OP_HALT : OP_BAD;
  endfunction
endpackage

// File: rtl/seq_program_controller_if.sv
// seq_program_controller_if: control, ROM and datapath signals of the program sequencer
// master: the sequencer (drives pc, datapath enable/opcode/a/b, status flags)
// slave: its environment (drives go/abort, ROM instruction, datapath done)
interface seq_program_controller_if #(
  parameter int OP_W = 4,
  parameter int DATA_W = 8,
  parameter int ADDR = 5
);
  logic go, abort, done, enable, busy, prog_done, invalid_opcode, timeout;
  logic [OP_W+2*DATA_W-1:0] instruction;
  logic [ADDR-1:0] pc;
  logic [OP_W-1:0] opcode;
  logic [DATA_W-1:0] a, b;
  modport master (
    input go, abort, instruction, done,
    output enable, pc, opcode, a, b, busy, prog_done, invalid_opcode, timeout
  );
  modport slave (
    output go, abort, instruction, done,
    input enable, pc, opcode, a, b, busy, prog_done, invalid_opcode, timeout
  );
endinterface

// File: rtl/seq_program_controller_watchdog.sv
// exec_watchdog: counts consecutive EXEC cycles and flags the cycle in which the limit is reached
// ports: clk, reset (async, active high), count_i (in EXEC), clear_i, expired_o
module exec_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic count_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= clear_i ? '0 : count_i ? cnt_q + 1'b1 : cnt_q;
  // cnt_q holds completed EXEC cycles, so this fires during the TIMEOUT-th one.
  assign expired_o = count_i && cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/seq_program_controller.sv
// seq_program_controller: fetch/decode/execute sequencer driving the ALU datapath from an instruction ROM
// ports: clk, reset (async, active high), bus (master side: go/abort/instruction/done in,
//        enable/pc/opcode/a/b/busy/prog_done/invalid_opcode/timeout out)
module seq_program_controller
  import seq_ctrl_pkg::*;
#(
  parameter int OP_W = DEF_OP_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR = DEF_ADDR,
  parameter int PROG_LEN = 2 ** ADDR,
  parameter int N_ALU_OPS = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  seq_program_controller_if.master bus
);
  localparam int INSTR_LEN = OP_W + 2 * DATA_W;
  state_e state_q, state_d;
  logic [ADDR-1:0] pc_q, pc_d;
  logic [OP_W-1:0] opcode_q, opcode_d, instr_op;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, instr_a, instr_b;
  logic inv_q, inv_d, to_q, to_d, prog_done_q, prog_done_d, enable_q, busy_q, expired;
  op_class_e cls;
  assign instr_op = bus.instruction[INSTR_LEN-1 -: OP_W];
  assign instr_a = bus.instruction[2*DATA_W-1 -: DATA_W];
  assign instr_b = bus.instruction[DATA_W-1:0];
  assign cls = op_class(32'(instr_op), OP_W, N_ALU_OPS);
  exec_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .reset(reset),
    .count_i(state_q == S_EXEC),
    .clear_i(state_q != S_EXEC),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    opcode_d = opcode_q;
    a_d = a_q;
    b_d = b_q;
    inv_d = inv_q;
    to_d = to_q;
    prog_done_d = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      pc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.go) begin
          state_d = S_FETCH;
          pc_d = '0;
        end
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          opcode_d = instr_op;
          a_d = instr_a;
          b_d = instr_b;
          case (cls)
            OP_ALU: state_d = S_EXEC;
            OP_NOP: begin
              state_d = S_FETCH;
              pc_d = pc_q + 1'b1;
            end
            OP_JMP: begin
              state_d = S_FETCH;
              pc_d = instr_b[ADDR-1:0];
            end
            OP_HALT: begin
              state_d = S_IDLE;
              pc_d = '0;
              prog_done_d = 1'b1;
            end
            default: begin
              state_d = S_ERROR;
              inv_d = 1'b1;
            end
          endcase
        end
        // done is checked before the watchdog so a completion in the expiry cycle still counts.
        S_EXEC: if (bus.done) begin
          state_d = pc_q == ADDR'(PROG_LEN - 1) ? S_IDLE : S_FETCH;
          pc_d = pc_q == ADDR'(PROG_LEN - 1) ? '0 : pc_q + 1'b1;
          prog_done_d = pc_q == ADDR'(PROG_LEN - 1);
        end else if (expired) begin
          state_d = S_ERROR;
          to_d = 1'b1;
        end
        S_ERROR: if (bus.go) begin
          state_d = S_IDLE;
          inv_d = 1'b0;
          to_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      opcode_q <= '0;
      a_q <= '0;
      b_q <= '0;
      inv_q <= 1'b0;
      to_q <= 1'b0;
      prog_done_q <= 1'b0;
      enable_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      opcode_q <= opcode_d;
      a_q <= a_d;
      b_q <= b_d;
      inv_q <= inv_d;
      to_q <= to_d;
      prog_done_q <= prog_done_d;
      enable_q <= state_d == S_EXEC;
      busy_q <= state_d inside {S_FETCH, S_DECODE, S_EXEC};
    end
  assign bus.enable = enable_q;
  assign bus.busy = busy_q;
  assign bus.pc = pc_q;
  assign bus.opcode = opcode_q;
  assign bus.a = a_q;
  assign bus.b = b_q;
  assign bus.prog_done = prog_done_q;
  assign bus.invalid_opcode = inv_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_seq_program_controller.sv
// tb_seq_program_controller: scoreboard bench running small ROM programs through the sequencer
module tb_seq_program_controller;
  localparam int PL = 4;
  localparam int NOP = 13, JMP = 14, HALT = 15;
  localparam int K_EXEC = 0, K_END = 1, K_INV = 2, K_TO = 3;
  typedef struct {int kind; int pc; int op; int a; int b;} ev_t;
  logic clk = 1'b0;
  logic reset;
  logic [19:0] rom [32];
  ev_t sb[$];
  int vecs = 0, errs = 0;
  int fe, ec;
  seq_program_controller_if #(.OP_W(4), .DATA_W(8), .ADDR(5)) bus ();
  seq_program_controller #(.PROG_LEN(PL)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk) bus.instruction <= rom[bus.pc];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] ins(input int op, input int a, input int b);
    return {4'(op), 8'(a), 8'(b)};
  endfunction
  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = ins(HALT, 0, 0);
  endtask
  // Instruction-level walk of the ROM producing the expected event stream.
  task automatic build(input int delay);
    int pc, op, a, b;
    logic [19:0] w;
    pc = 0;
    sb.delete();
    for (int s = 0; s < 64; s++) begin
      w = rom[pc];
      op = int'(w[19:16]);
      a = int'(w[15:8]);
      b = int'(w[7:0]);
      if (op < 4) begin
        sb.push_back('{K_EXEC, pc, op, a, b});
        if (delay == 0) begin
          sb.push_back('{K_TO, 0, 0, 0, 0});
          return;
        end
        if (pc == PL - 1) begin
          sb.push_back('{K_END, 0, 0, 0, 0});
          return;
        end
        pc = (pc + 1) % 32;
      end else if (op == NOP) pc = (pc + 1) % 32;
      else if (op == JMP) pc = b % 32;
      else if (op == HALT) begin
        sb.push_back('{K_END, 0, 0, 0, 0});
        return;
      end else begin
        sb.push_back('{K_INV, 0, 0, 0, 0});
        return;
      end
    end
  endtask
  task automatic pop(output ev_t e);
    chk("sb_avail", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{99, 0, 0, 0, 0};
  endtask
  task automatic pulse_go();
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask
  task automatic wait_en();
    for (int i = 0; i < 10 && !bus.enable; i++) @(negedge clk);
    chk("wait_en", bus.enable, 1);
  endtask
  // Starts the program, answers each datapath op with done after `delay` EXEC cycles
  // (0 = never), and checks every op issue and the way the program ends.
  task automatic run(input int delay, output int first_en, output int en_cyc);
    ev_t e;
    int cnt, obs;
    logic prev_en;
    bit fin;
    build(delay);
    pulse_go();
    prev_en = 1'b0;
    first_en = 0;
    en_cyc = 0;
    cnt = 0;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      bus.done = 1'b0;
      if (bus.enable && !prev_en) begin
        if (first_en == 0) first_en = cyc;
        pop(e);
        chk("exec_kind", K_EXEC, e.kind);
        chk("exec_pc", bus.pc, e.pc);
        chk("exec_opcode", bus.opcode, e.op);
        chk("exec_a", bus.a, e.a);
        chk("exec_b", bus.b, e.b);
        cnt = delay;
      end
      if (bus.enable) en_cyc++;
      if (bus.enable && cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.done = 1'b1;
      end
      if (!bus.busy) begin
        fin = 1'b1;
        pop(e);
        obs = bus.prog_done ? K_END : bus.invalid_opcode ? K_INV : bus.timeout ? K_TO : 99;
        chk("end_kind", obs, e.kind);
        chk("end_enable", bus.enable, 0);
        if (e.kind == K_END) chk("end_pc", bus.pc, 0);
      end
      prev_en = bus.enable;
      if (!fin) @(negedge clk);
    end
    bus.done = 1'b0;
    chk("finished", 32'(fin), 1);
    chk("sb_empty", sb.size(), 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.go = 1'b0;
    bus.abort = 1'b0;
    bus.done = 1'b0;
    clear_rom();
    repeat (3) @(negedge clk);
    chk("rst_pc", bus.pc, 0);
    chk("rst_enable", bus.enable, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_flags", {bus.prog_done, bus.invalid_opcode, bus.timeout}, 0);
    chk("rst_opab", {bus.opcode, bus.a, bus.b}, 0);
    reset = 1'b0;
    @(negedge clk);
    rom[0] = ins(0, 8'h11, 8'h22);
    rom[1] = ins(1, 8'h33, 8'h44);
    rom[2] = ins(HALT, 0, 0);
    run(2, fe, ec);
    chk("t1_enable_latency", fe, 3);
    chk("t1_enable_cycles", ec, 4);
    @(negedge clk);
    chk("t1_prog_done_pulse", bus.prog_done, 0);
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = ins(i, 16 * i + 1, 255 - i);
    run(2, fe, ec);
    @(negedge clk);
    chk("t2_no_wrap_busy", bus.busy, 0);
    chk("t2_no_wrap_pc", bus.pc, 0);
    clear_rom();
    rom[0] = ins(NOP, 0, 0);
    rom[1] = ins(JMP, 0, 5);
    rom[2] = ins(0, 1, 1);
    rom[5] = ins(NOP, 0, 0);
    rom[6] = ins(2, 8'hA5, 8'h5A);
    rom[7] = ins(HALT, 0, 0);
    run(2, fe, ec);
    chk("t3_enable_cycles", ec, 2);
    clear_rom();
    rom[0] = ins(NOP, 0, 0);
    rom[1] = ins(NOP, 0, 0);
    rom[2] = ins(9, 1, 2);
    run(2, fe, ec);
    chk("t4_opcode", bus.opcode, 9);
    chk("t4_inv", bus.invalid_opcode, 1);
    repeat (2) @(negedge clk);
    chk("t4_inv_held", bus.invalid_opcode, 1);
    chk("t4_err_enable", bus.enable, 0);
    pulse_go();
    chk("t4_inv_cleared", bus.invalid_opcode, 0);
    @(negedge clk);
    chk("t4_idle_busy", bus.busy, 0);
    clear_rom();
    rom[0] = ins(3, 7, 8);
    run(0, fe, ec);
    chk("t5_enable_cycles", ec, 64);
    chk("t5_timeout", bus.timeout, 1);
    pulse_go();
    chk("t5_timeout_cleared", bus.timeout, 0);
    rom[1] = ins(HALT, 0, 0);
    run(64, fe, ec);
    chk("t6_enable_cycles", ec, 64);
    chk("t6_no_timeout", bus.timeout, 0);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    @(negedge clk);
    chk("t7_idle_done_busy", bus.busy, 0);
    chk("t7_idle_done_flag", bus.prog_done, 0);
    pulse_go();
    wait_en();
    bus.done = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    bus.abort = 1'b0;
    chk("t8_abort_busy", bus.busy, 0);
    chk("t8_abort_enable", bus.enable, 0);
    chk("t8_abort_pc", bus.pc, 0);
    chk("t8_abort_prog_done", bus.prog_done, 0);
    @(negedge clk);
    chk("t8_abort_stays_idle", bus.busy, 0);
    rom[0] = ins(NOP, 0, 0);
    rom[1] = ins(1, 8'h0F, 8'hF0);
    pulse_go();
    wait_en();
    chk("t9_exec_pc", bus.pc, 1);
    #2 reset = 1'b1;
    #1;
    chk("t9_rst_enable", bus.enable, 0);
    chk("t9_rst_busy", bus.busy, 0);
    chk("t9_rst_pc", bus.pc, 0);
    chk("t9_rst_opab", {bus.opcode, bus.a, bus.b}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t9_after_rst_busy", bus.busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
